time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Timekeeping and time-set controller for the watch. Keeps hours/minutes/seconds from a divided system clock. Runs a mode FSM driven by two debounced buttons. Drives the per-field blink enables into the downstream blink stages (one blink instance per displayed field), so the field being edited flashes while the others stay steady.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick; legal range 2..2^26.
REPEAT_DELAY, 25000000, cycles btn_inc must be held before auto-repeat starts (AUTO_REPEAT_EN only).
REPEAT_RATE, 5000000, cycles between auto-repeat increments (AUTO_REPEAT_EN only).

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  debounced, synchronised level; high = pressed
btn_inc  input  1  debounced, synchronised level; high = pressed
hour  output  5  hours, 0..23
min  output  6  minutes, 0..59
sec  output  6  seconds, 0..59
blink_on  output  3  blink enables; bit2 = hour, bit1 = min, bit0 = sec
running  output  1  high in RUN state

Behaviour:
- Reset (rst_n low, async): hour = min = sec = 0; divider = 0; state RUN; blink_on = 3'b000; running = 1; button edge registers = 0.
- Edge detect: prev_mode/prev_inc registered every cycle. Press = btn high AND prev low. A held button produces exactly one press.
- Latency: press sampled at edge N; state/field change is visible after edge N+1. All outputs are registered.
- FSM states: RUN, SET_H, SET_M, SET_S.
  - RUN -> SET_H on mode press.
  - SET_H -> SET_M on mode press.
  - SET_M -> SET_S on mode press.
  - SET_S -> RUN on mode press.
- blink_on by state: RUN = 000, SET_H = 100, SET_M = 010, SET_S = 001.
- running = 1 only in RUN.
- RUN timekeeping:
  - Divider counts 0..TICK_DIV-1 and wraps to 0.
  - Tick on the cycle divider == TICK_DIV-1.
  - On tick, sec increments; 59 -> 0 with carry into min; min 59 -> 0 with carry into hour; hour 23 -> 0.
  - 23:59:59 + tick -> 00:00:00 on a single edge.
- SET states:
  - Divider held at 0; no ticks.
  - inc press increments only the selected field, with wrap (hour 23 -> 0, min/sec 59 -> 0) and no carry into other fields.
- Mode press while in a SET state: the current field is kept as edited.
- Transition SET_S -> RUN: divider is already 0, so the first tick occurs TICK_DIV cycles after entering RUN.
- Mode press and inc press in the same cycle: mode wins; the inc is discarded (no field change).
- inc press in RUN: ignored.
- Tick coinciding with a mode press (RUN -> SET_H): the tick increment is applied, then the state changes; both are visible after the same edge.
- Reset asserted mid-edit: immediate return to RUN, 00:00:00.
- Buttons asserted at reset release: prev registers are 0, so a held button registers one press on the first edge after release. This is intended.
- Field registers never hold out-of-range values. An increment from any legal value yields a legal value.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - In SET_H/SET_M/SET_S, holding btn_inc continuously for REPEAT_DELAY cycles after the press produces one extra increment.
  - Further increments follow every REPEAT_RATE cycles while btn_inc stays high.
  - Hold counter clears on btn_inc low, on any mode press, on leaving a SET state, and on reset.
  - Repeat increments obey the same wrap and mode-priority rules as presses.
- Not defined: exactly one increment per press regardless of hold time; REPEAT_* parameters are unused and no hold counter is synthesised.

Test Plan:
- TICK_DIV = 4, reset, no buttons, run 240 cycles -> sec = 0 -> 59 -> min = 1, sec = 0 at cycle 240; blink_on = 000, running = 1 throughout.
- Force 23:59:59 via set mode, return to RUN, wait 4 cycles -> 00:00:00 after a single edge, no intermediate values.
- Mode press ×1 -> blink_on = 100, running = 0.
- Then: inc ×25 -> hour = 1 (wrap at 24); mode -> 010; inc ×60 -> min unchanged; mode ×2 -> RUN, blink_on = 000.
- In SET_M, btn_mode and btn_inc rise on the same cycle -> state SET_S, min unchanged.
- btn_inc held 1000 cycles with AUTO_REPEAT_EN undefined -> exactly +1.
- In SET_S at sec = 10, assert rst_n low mid-cycle -> outputs immediately 0, state RUN, running = 1 before the next clk edge.
- AUTO_REPEAT_EN, REPEAT_DELAY = 10, REPEAT_RATE = 5, SET_S, hold btn_inc 30 cycles from the press -> sec = 5 (press + repeats at 10, 15, 20, 25).

Source files
------------

// File: rtl/time_set_ctrl.sv
//-----------------------------------------------------------------------------
// time_set_ctrl
//
// Timekeeping and time-set controller for the watch. A divider turns clk
// into a 1 s tick that advances hour:min:sec while in RUN. A four-state mode
// FSM (RUN -> SET_H -> SET_M -> SET_S -> RUN) is stepped by btn_mode presses.
// In the SET states btn_inc presses advance only the selected field, with
// wrap and no carry. blink_on flags the field being edited so the downstream
// blink stage flashes it.
//
// Button presses are detected on the rising edge of the (already debounced
// and synchronised) level inputs. Each press is registered for one cycle
// before it acts, so a press sampled at edge N changes state/fields at N+1.
//
// Optional feature macro: AUTO_REPEAT_EN
//   Defined     : holding btn_inc in a SET state auto-repeats the increment,
//                 first after REPEAT_DELAY cycles, then every REPEAT_RATE.
//   Not defined : exactly one increment per press; no hold counter.
//
// Parameters:
//   TICK_DIV      clk cycles per 1 s tick (2 .. 2^26)
//   REPEAT_DELAY  hold cycles before the first auto-repeat increment
//   REPEAT_RATE   cycles between subsequent auto-repeat increments
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_mode  in   mode button level, high = pressed
//   btn_inc   in   increment button level, high = pressed
//   hour      out  [4:0] hours 0..23
//   min       out  [5:0] minutes 0..59
//   sec       out  [5:0] seconds 0..59
//   blink_on  out  [2:0] blink enables {hour, min, sec}
//   running   out  high while in RUN
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module time_set_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [2:0] blink_on,
    output logic       running
);

    localparam int DIV_W = $clog2(TICK_DIV);

    // Elaboration-time parameter legality checks.
    if (TICK_DIV < 2 || TICK_DIV > (1 << 26)) begin : g_bad_tick_div
        $error("time_set_ctrl: TICK_DIV out of range 2..2^26");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("time_set_ctrl: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         blink_q, blink_d;
    logic               running_q, running_d;
    logic               prev_mode_q, prev_inc_q;
    logic               mode_pls_q, mode_pls_d;
    logic               inc_pls_q, inc_pls_d;

    logic               mode_edge;
    logic               inc_edge;
    logic               inc_evt;
    logic               tick;

    // Wrapping increments. The >= compare keeps the result legal even if a
    // field were ever out of range.
    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v >= 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    assign mode_edge  = btn_mode & ~prev_mode_q;
    assign inc_edge   = btn_inc & ~prev_inc_q;
    assign mode_pls_d = mode_edge;
    assign inc_pls_d  = inc_edge;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_target;
    logic             rep_phase_q, rep_phase_d;
    logic             rep_pls_q, rep_pls_d;

    // rep_cnt counts consecutive held cycles since the press (phase 0) or
    // since the last repeat (phase 1). Reaching the phase target fires one
    // repeat and restarts counting toward REPEAT_RATE. Any mode press,
    // a released button or being in RUN clears everything.
    always_comb begin
        rep_target  = rep_phase_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_pls_d   = 1'b0;
        if (btn_inc && (state_q != ST_RUN) && !mode_edge) begin
            if (rep_cnt_q == rep_target) begin
                rep_pls_d   = 1'b1;
                rep_cnt_d   = REP_W'(1);
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d   = rep_cnt_q + REP_W'(1);
                rep_phase_d = rep_phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            rep_pls_q   <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            rep_pls_q   <= rep_pls_d;
        end
    end

    assign inc_evt = inc_pls_q | rep_pls_q;
`else
    assign inc_evt = inc_pls_q;
`endif

    // Next-state, divider and field update.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        div_d   = div_q;
        tick    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (div_q == DIV_W'(TICK_DIV - 1)) begin
                    tick  = 1'b1;
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
                if (tick) begin
                    sec_d = inc_mod60(sec_q);
                    if (sec_q >= 6'd59) begin
                        min_d = inc_mod60(min_q);
                        if (min_q >= 6'd59) begin
                            hour_d = inc_mod24(hour_q);
                        end
                    end
                end
                // A coincident tick is still applied; only the state and the
                // divider are affected by the mode press. inc is ignored here.
                if (mode_pls_q) begin
                    state_d = ST_SET_H;
                    div_d   = '0;
                end
            end
            ST_SET_H: begin
                div_d = '0;
                if (mode_pls_q) begin
                    state_d = ST_SET_M;
                end else if (inc_evt) begin
                    hour_d = inc_mod24(hour_q);
                end
            end
            ST_SET_M: begin
                div_d = '0;
                if (mode_pls_q) begin
                    state_d = ST_SET_S;
                end else if (inc_evt) begin
                    min_d = inc_mod60(min_q);
                end
            end
            ST_SET_S: begin
                // Divider is already 0 here, so the first tick after return
                // to RUN lands a full TICK_DIV cycles later.
                div_d = '0;
                if (mode_pls_q) begin
                    state_d = ST_RUN;
                end else if (inc_evt) begin
                    sec_d = inc_mod60(sec_q);
                end
            end
            default: begin
                state_d = ST_RUN;
                div_d   = '0;
            end
        endcase
    end

    // Registered outputs follow the next state so they change on the same
    // edge as the state itself.
    always_comb begin
        blink_d   = 3'b000;
        running_d = 1'b0;
        case (state_d)
            ST_RUN:   running_d = 1'b1;
            ST_SET_H: blink_d   = 3'b100;
            ST_SET_M: blink_d   = 3'b010;
            ST_SET_S: blink_d   = 3'b001;
            default:  running_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            div_q       <= '0;
            blink_q     <= 3'b000;
            running_q   <= 1'b1;
            prev_mode_q <= 1'b0;
            prev_inc_q  <= 1'b0;
            mode_pls_q  <= 1'b0;
            inc_pls_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            div_q       <= div_d;
            blink_q     <= blink_d;
            running_q   <= running_d;
            prev_mode_q <= btn_mode;
            prev_inc_q  <= btn_inc;
            mode_pls_q  <= mode_pls_d;
            inc_pls_q   <= inc_pls_d;
        end
    end

    assign hour     = hour_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign blink_on = blink_q;
    assign running  = running_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
//-----------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Self-checking bench for time_set_ctrl with TICK_DIV = 4, REPEAT_DELAY = 10,
// REPEAT_RATE = 5. Directed table of button patterns, hand-written corner
// sequences, and a randomized run compared against a time-of-day model.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_time_set_ctrl;

    localparam int TICK_DIV = 4;
    localparam int RD       = 10;
    localparam int RR       = 5;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [2:0] blink_on;
    logic       running;

    int total = 0;
    int bad   = 0;

    time_set_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .blink_on (blink_on),
        .running  (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got total=%0d required completion", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int h, input int m, input int s,
                             input int b, input int r);
        check({tag, ".hour"},     int'(hour),     h);
        check({tag, ".min"},      int'(min),      m);
        check({tag, ".sec"},      int'(sec),      s);
        check({tag, ".blink_on"}, int'(blink_on), b);
        check({tag, ".running"},  int'(running),  r);
    endtask

    // Reset held across two edges, released at a falling edge with buttons low.
    task automatic do_reset();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One "rep" = buttons high for one cycle then low for one cycle.
    task automatic press(input logic bm, input logic bi, input int reps);
        for (int i = 0; i < reps; i++) begin
            btn_mode = bm;
            btn_inc  = bi;
            @(negedge clk);
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            @(negedge clk);
        end
    endtask

    // ---------------- reference model: time of day in seconds ----------------
    int m_tod, m_mode, m_div, m_hold;
    bit m_pm, m_pi, m_pend_mode, m_pend_inc, m_pend_rep;

    task automatic model_reset();
        m_tod = 0; m_mode = 0; m_div = 0; m_hold = 0;
        m_pm = 0; m_pi = 0; m_pend_mode = 0; m_pend_inc = 0; m_pend_rep = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        bit medge;
        bit fire;
        int h, mi, s;
        medge = bm && !m_pm;
        fire  = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (m_mode != 0 && bi && !medge) begin
            fire = (m_hold >= RD) && (((m_hold - RD) % RR) == 0);
            m_hold++;
        end else begin
            m_hold = 0;
        end
`endif
        if (m_mode == 0) begin
            m_div++;
            if (m_div == TICK_DIV) begin
                m_div = 0;
                m_tod = (m_tod + 1) % 86400;
            end
            if (m_pend_mode) begin
                m_mode = 1;
                m_div  = 0;
            end
        end else if (m_pend_mode) begin
            m_mode = (m_mode + 1) % 4;
            m_div  = 0;
        end else if (m_pend_inc || m_pend_rep) begin
            h  = m_tod / 3600;
            mi = (m_tod / 60) % 60;
            s  = m_tod % 60;
            case (m_mode)
                1: h  = (h + 1) % 24;
                2: mi = (mi + 1) % 60;
                default: s = (s + 1) % 60;
            endcase
            m_tod = h * 3600 + mi * 60 + s;
        end
        m_pend_mode = medge;
        m_pend_inc  = bi && !m_pi;
        m_pend_rep  = fire;
        m_pm = bm;
        m_pi = bi;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic bm;
        logic bi;
        int   reps;
        int   h, m, s, b, r;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int hold_cycles, exp_hold;

        tbl[0]  = '{1'b1, 1'b0,  1,  0,  0, 0, 4, 0};  // RUN -> SET_H
        tbl[1]  = '{1'b0, 1'b1, 25,  1,  0, 0, 4, 0};  // hour wraps at 24
        tbl[2]  = '{1'b1, 1'b0,  1,  1,  0, 0, 2, 0};  // -> SET_M
        tbl[3]  = '{1'b0, 1'b1, 60,  1,  0, 0, 2, 0};  // 60 incs: min unchanged
        tbl[4]  = '{1'b0, 1'b1, 59,  1, 59, 0, 2, 0};
        tbl[5]  = '{1'b1, 1'b0,  1,  1, 59, 0, 1, 0};  // -> SET_S
        tbl[6]  = '{1'b0, 1'b1, 59,  1, 59,59, 1, 0};  // no carry into min
        tbl[7]  = '{1'b1, 1'b0,  1,  1, 59,59, 0, 1};  // -> RUN
        tbl[8]  = '{1'b0, 1'b0,  2,  2,  0, 0, 0, 1};  // first tick 4 cycles later
        tbl[9]  = '{1'b1, 1'b1,  1,  2,  0, 0, 4, 0};  // inc in RUN ignored
        tbl[10] = '{1'b1, 1'b0,  1,  2,  0, 0, 2, 0};
        tbl[11] = '{1'b1, 1'b1,  1,  2,  0, 0, 1, 0};  // mode wins over inc
        tbl[12] = '{1'b0, 1'b1,  3,  2,  0, 3, 1, 0};
        tbl[13] = '{1'b1, 1'b0,  1,  2,  0, 3, 0, 1};

        // Reset state, applied by the first clock edge with rst_n low.
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            press(tbl[i].bm, tbl[i].bi, tbl[i].reps);
            check_all($sformatf("tbl%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].b, tbl[i].r);
        end

        // Free run from reset: 240 cycles -> 00:01:00, one second every 4 edges.
        do_reset();
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            total++;
            if (int'(min) * 60 + int'(sec) != k / 4 || hour != 5'd0 ||
                blink_on != 3'b000 || running != 1'b1) begin
                bad++;
                $display("FAIL run240 cycle %0d: got %0d:%0d:%0d blink=%0d run=%0d expected 0:%0d:%0d blink=0 run=1",
                         k, hour, min, sec, blink_on, running, (k / 4) / 60, (k / 4) % 60);
            end
        end
        check_all("run240", 0, 1, 0, 0, 1);

        // Force 23:59:59 then roll over on a single edge.
        do_reset();
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 23);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 59);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 59);
        press(1'b1, 1'b0, 1);
        check_all("set235959", 23, 59, 59, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_all($sformatf("pre_roll%0d", k), 23, 59, 59, 0, 1);
        end
        @(negedge clk);
        check_all("rollover", 0, 0, 0, 0, 1);

        // Long hold of btn_inc in SET_S.
        do_reset();
        press(1'b1, 1'b0, 3);
`ifdef AUTO_REPEAT_EN
        hold_cycles = 30;
        exp_hold    = 5;
`else
        hold_cycles = 1000;
        exp_hold    = 1;
`endif
        btn_inc = 1'b1;
        repeat (hold_cycles) @(negedge clk);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        check_all("hold_inc", 0, 0, exp_hold, 1, 0);

        // Asynchronous reset mid-edit.
        do_reset();
        press(1'b1, 1'b0, 3);
        press(1'b0, 1'b1, 10);
        check_all("pre_async", 0, 0, 10, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode held through reset release: exactly one press.
        btn_mode = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("held_rel.edge1.running", int'(running), 1);
        @(negedge clk);
        check("held_rel.edge2.blink", int'(blink_on), 4);
        repeat (10) @(negedge clk);
        check("held_rel.later.blink", int'(blink_on), 4);
        btn_mode = 1'b0;

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            btn_mode = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 11) == 0) btn_inc = ~btn_inc;
            @(posedge clk);
            model_step(btn_mode, btn_inc);
            @(negedge clk);
            total++;
            if (int'(hour) != m_tod / 3600 || int'(min) != (m_tod / 60) % 60 ||
                int'(sec) != m_tod % 60 ||
                int'(blink_on) != ((m_mode == 0) ? 0 : (4 >> (m_mode - 1))) ||
                int'(running) != ((m_mode == 0) ? 1 : 0)) begin
                bad++;
                $display("FAIL rand cycle %0d: got %0d:%0d:%0d blink=%0d run=%0d expected %0d:%0d:%0d mode=%0d",
                         i, hour, min, sec, blink_on, running,
                         m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode);
            end
        end
        btn_mode = 1'b0;
        btn_inc  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
